// File: rtl/mem_loader.sv
// Byte-stream memory loader: parses host command bytes and writes 16-bit
// words into an instruction or data memory, then controls CPU enable/start.
module mem_loader #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter logic [7:0]  HDR_I    = 8'hA5,
    parameter logic [7:0]  HDR_D    = 8'h5A,
    parameter logic [7:0]  HDR_GO   = 8'hC3,
    parameter logic [7:0]  HDR_STOP = 8'h3C
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              i_we,
    output logic              d_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_enable,
    output logic              cpu_start,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CNT,
        HI,
        LO,
        WR,
        GO
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [7:0]        count;
    logic [7:0]        hi_byte;
    logic              target_i;
    logic              accept;

    // Handshake and busy are decoded straight from the state register
    always_comb begin
        in_ready = (state != WR) && (state != GO);
        busy     = (state != IDLE);
        accept   = in_valid && in_ready;
    end

    // Command parser, word assembler and write/start sequencing.
    // mem_addr/mem_wdata are loaded only on entry to WR so they stay
    // stable through the strobe and hold their value everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            count      <= '0;
            hi_byte    <= '0;
            target_i   <= 1'b0;
            i_we       <= 1'b0;
            d_we       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_enable <= 1'b0;
            cpu_start  <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_byte == HDR_I) begin
                            target_i <= 1'b1;
                            state    <= ADDR;
                        end else if (in_byte == HDR_D) begin
                            target_i <= 1'b0;
                            state    <= ADDR;
                        end else if (in_byte == HDR_GO) begin
                            cpu_start  <= 1'b1;
                            cpu_enable <= 1'b1;
                            state      <= GO;
                        end else if (in_byte == HDR_STOP) begin
                            cpu_enable <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (accept) begin
                        addr_cnt <= ADDR_W'(in_byte);
                        state    <= CNT;
                    end
                end
                CNT: begin
                    if (accept) begin
                        count <= in_byte;
                        state <= (in_byte == 8'd0) ? IDLE : HI;
                    end
                end
                HI: begin
                    if (accept) begin
                        hi_byte <= in_byte;
                        state   <= LO;
                    end
                end
                LO: begin
                    if (accept) begin
                        mem_addr  <= addr_cnt;
                        mem_wdata <= DATA_W'({hi_byte, in_byte});
                        i_we      <= target_i;
                        d_we      <= ~target_i;
                        state     <= WR;
                    end
                end
                WR: begin
                    i_we     <= 1'b0;
                    d_we     <= 1'b0;
                    addr_cnt <= addr_cnt + ADDR_W'(1);
                    count    <= count - 8'd1;
                    state    <= (count == 8'd1) ? IDLE : HI;
                end
                GO: begin
                    cpu_start <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
